// File: rtl/flit_checker_sink.sv
`default_nettype none
// ============================================================================
//  Module   : flit_checker_sink
//  Purpose  : Self-checking traffic sink for one router output port. Accepts
//             flits on a req/ack handshake with deterministic LFSR
//             backpressure. Checks every accepted flit against the reference
//             source stream, which has a fixed destination field and a
//             payload that increments by one per flit. Reports counts,
//             first-error capture and completion/timeout status.
//  Ports    : clk            - clock, rising edge
//             reset          - asynchronous, active-low reset
//             req            - flit valid from upstream tx port
//             ack            - ready; transfer when req & ack on rising clk
//             data           - flit, sampled only on a transfer edge
//             flit_count     - flits accepted
//             error_count    - failing flits accepted (saturates at 255)
//             first_err_data - data of the first failing flit
//             done           - MAX_FLITS flits accepted
//             timed_out      - idle limit expired before done
//  Revision : 1.0 - initial release
// ============================================================================
module flit_checker_sink #(
  parameter int ID               = 0,
  parameter int SIZE             = 8,
  parameter int DESTINATION_BITS = 3,
  parameter int EXP_DEST         = 4,
  parameter int EXP_PAYLOAD      = 10,
  parameter int MAX_FLITS        = 4,
  parameter int STALL_EN         = 1,
  parameter int TIMEOUT          = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  output logic            ack,
  input  logic [SIZE-1:0] data,
  output logic [7:0]      flit_count,
  output logic [7:0]      error_count,
  output logic [SIZE-1:0] first_err_data,
  output logic            done,
  output logic            timed_out
);

  localparam int c_pay_w = SIZE - DESTINATION_BITS;

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_recv    = 2'd1;
  localparam logic [1:0] c_st_done    = 2'd2;
  localparam logic [1:0] c_st_timeout = 2'd3;

  localparam logic [7:0]                  c_id8        = 8'(ID);
  localparam logic [7:0]                  c_seed_raw   = 8'hA5 ^ c_id8;
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [7:0]                  c_seed       = (c_seed_raw == 8'h00) ? 8'h01 : c_seed_raw;
  localparam logic [DESTINATION_BITS-1:0] c_exp_dest   = DESTINATION_BITS'(EXP_DEST);
  localparam logic [c_pay_w-1:0]          c_exp_pay0   = c_pay_w'(EXP_PAYLOAD);
  localparam logic [7:0]                  c_max_flits  = 8'(MAX_FLITS);
  localparam logic [15:0]                 c_idle_last  = 16'(TIMEOUT - 1);

  logic [1:0]      r_state;
  logic [7:0]      r_lfsr;
  logic            r_ack;
  logic [15:0]     r_idle;
  logic [7:0]      r_flit_count;
  logic [7:0]      r_error_count;
  logic [SIZE-1:0] r_first_err_data;

  logic [1:0]                  w_state_nxt;
  logic [7:0]                  w_lfsr_nxt;
  logic                        w_xfer;
  logic                        w_bad;
  logic [7:0]                  w_flit_inc;
  logic [c_pay_w-1:0]          w_exp_payload;
  logic [DESTINATION_BITS-1:0] w_dest;
  logic [c_pay_w-1:0]          w_payload;

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1: feedback from bits 7,5,4,3.
  assign w_lfsr_nxt = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  assign w_xfer        = (r_state == c_st_recv) & req & r_ack;
  assign w_flit_inc    = r_flit_count + 8'd1;
  // Sum is taken in payload width so it wraps modulo 2^(SIZE-DESTINATION_BITS).
  assign w_exp_payload = c_exp_pay0 + c_pay_w'(r_flit_count);
  assign w_dest        = data[SIZE-1 -: DESTINATION_BITS];
  assign w_payload     = data[c_pay_w-1:0];
  assign w_bad         = (w_dest != c_exp_dest) | (w_payload != w_exp_payload);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: w_state_nxt = c_st_recv;
      c_st_recv: begin
        // A transfer on the last idle cycle beats the timeout.
        if (w_xfer) begin
          if (w_flit_inc == c_max_flits) begin
            w_state_nxt = c_st_done;
          end
        end else if (r_idle == c_idle_last) begin
          w_state_nxt = c_st_timeout;
        end
      end
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= c_st_idle;
      r_lfsr           <= c_seed;
      r_ack            <= 1'b0;
      r_idle           <= 16'd0;
      r_flit_count     <= 8'd0;
      r_error_count    <= 8'd0;
      r_first_err_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= w_lfsr_nxt;
      // ack is a flop loaded with the value for the coming cycle, so it never
      // depends combinationally on req.
      r_ack   <= (w_state_nxt == c_st_recv) & ((STALL_EN != 0) ? w_lfsr_nxt[0] : 1'b1);

      if (r_state == c_st_recv) begin
        r_idle <= w_xfer ? 16'd0 : r_idle + 16'd1;
      end

      if (w_xfer) begin
        r_flit_count <= w_flit_inc;
        if (w_bad) begin
          if (r_error_count == 8'd0) begin
            r_first_err_data <= data;
          end
          if (r_error_count != 8'hFF) begin
            r_error_count <= r_error_count + 8'd1;
          end
        end
      end
    end
  end

  assign ack            = r_ack;
  assign flit_count     = r_flit_count;
  assign error_count    = r_error_count;
  assign first_err_data = r_first_err_data;
  assign done           = (r_state == c_st_done);
  assign timed_out      = (r_state == c_st_timeout);

endmodule
`default_nettype wire

// File: tb/tb_flit_checker_sink.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flit_checker_sink
//  Purpose  : Scoreboard bench for flit_checker_sink. Channel 0 runs with
//             LFSR backpressure (ID 0, payload from 10, 4 flits); channel 1
//             runs with ack held high (payload from 30 with wrap, 5 flits,
//             idle limit 8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_flit_checker_sink;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst_v  = 2'b00;
  logic [1:0]      req_v  = 2'b00;
  logic [1:0][7:0] data_v = '0;
  logic [1:0]      ack_v, done_v, to_v;
  logic [1:0][7:0] fc_v, ec_v, fe_v;

  int checks = 0;
  int errors = 0;

  flit_checker_sink #(.ID(0), .SIZE(8), .DESTINATION_BITS(3), .EXP_DEST(4),
    .EXP_PAYLOAD(10), .MAX_FLITS(4), .STALL_EN(1), .TIMEOUT(64)) u0 (
    .clk(clk), .reset(rst_v[0]), .req(req_v[0]), .ack(ack_v[0]), .data(data_v[0]),
    .flit_count(fc_v[0]), .error_count(ec_v[0]), .first_err_data(fe_v[0]),
    .done(done_v[0]), .timed_out(to_v[0]));

  flit_checker_sink #(.ID(3), .SIZE(8), .DESTINATION_BITS(3), .EXP_DEST(4),
    .EXP_PAYLOAD(30), .MAX_FLITS(5), .STALL_EN(0), .TIMEOUT(8)) u1 (
    .clk(clk), .reset(rst_v[1]), .req(req_v[1]), .ack(ack_v[1]), .data(data_v[1]),
    .flit_count(fc_v[1]), .error_count(ec_v[1]), .first_err_data(fe_v[1]),
    .done(done_v[1]), .timed_out(to_v[1]));

  typedef struct {
    logic [7:0] cnt;
    logic [7:0] err;
    logic [7:0] first;
    logic       done;
  } exp_t;

  exp_t       sbq0[$];
  exp_t       sbq1[$];
  int         m_cnt[2];
  int         m_err[2];
  logic [7:0] m_first[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int first_payload(input int ch);
    return (ch == 0) ? 10 : 30;
  endfunction

  function automatic int max_of(input int ch);
    return (ch == 0) ? 4 : 5;
  endfunction

  // The flit a correct source would send next on this channel.
  function automatic logic [7:0] good_flit(input int ch);
    return {3'd4, 5'((first_payload(ch) + m_cnt[ch]) % 32)};
  endfunction

  // Predict the status after this flit is accepted and queue it.
  task automatic model_push(input int ch, input logic [7:0] d);
    exp_t e;
    logic bad;
    bad = (d != good_flit(ch));
    m_cnt[ch]++;
    if (bad) begin
      if (m_err[ch] == 0) m_first[ch] = d;
      if (m_err[ch] < 255) m_err[ch]++;
    end
    e.cnt   = 8'(m_cnt[ch]);
    e.err   = 8'(m_err[ch]);
    e.first = m_first[ch];
    e.done  = (m_cnt[ch] == max_of(ch));
    if (ch == 0) sbq0.push_back(e);
    else         sbq1.push_back(e);
  endtask

  task automatic clear_model(input int ch);
    m_cnt[ch] = 0;
    m_err[ch] = 0;
    m_first[ch] = 8'h00;
    if (ch == 0) sbq0.delete();
    else         sbq1.delete();
  endtask

  task automatic chk_zero(input int ch, input string tag);
    chk($sformatf("ch%0d %s outputs_cleared", ch, tag),
        {5'd0, ack_v[ch], done_v[ch], to_v[ch], fc_v[ch], ec_v[ch], fe_v[ch]}, 32'd0);
  endtask

  task automatic reset_both();
    @(negedge clk);
    rst_v = 2'b00;
    req_v = 2'b00;
    #1;
    for (int ch = 0; ch < 2; ch++) begin
      chk_zero(ch, "reset");
      clear_model(ch);
    end
    @(negedge clk);
    rst_v = 2'b11;
  endtask

  // Offer one flit after 'gap' idle cycles, hold it until accepted.
  task automatic send(input int ch, input logic [7:0] d, input int gap, output int waits);
    req_v[ch] = 1'b0;
    repeat (gap) @(negedge clk);
    req_v[ch]  = 1'b1;
    data_v[ch] = d;
    model_push(ch, d);
    waits = 0;
    while (ack_v[ch] !== 1'b1) begin
      @(negedge clk);
      waits++;
      if (waits > 200) begin
        chk($sformatf("ch%0d ack_wait_bound", ch), ack_v[ch], 1);
        break;
      end
    end
    @(negedge clk);
    req_v[ch] = 1'b0;
  endtask

  task automatic rnd_flit(input int ch, output logic [7:0] d);
    d = good_flit(ch);
    if ($urandom_range(0, 3) == 0) d = d ^ (8'h01 << $urandom_range(0, 7));
  endtask

  task automatic final_chk(input int ch, input logic exp_done, input logic exp_to);
    chk($sformatf("ch%0d final flit_count", ch), fc_v[ch], m_cnt[ch]);
    chk($sformatf("ch%0d final error_count", ch), ec_v[ch], m_err[ch]);
    chk($sformatf("ch%0d final first_err_data", ch), fe_v[ch], m_first[ch]);
    chk($sformatf("ch%0d final done", ch), done_v[ch], exp_done);
    chk($sformatf("ch%0d final timed_out", ch), to_v[ch], exp_to);
    if (exp_done || exp_to) chk($sformatf("ch%0d final ack", ch), ack_v[ch], 0);
    chk($sformatf("ch%0d pending_expectations", ch),
        (ch == 0) ? sbq0.size() : sbq1.size(), 0);
  endtask

  // Scoreboard monitor: on every transfer edge pop the prediction and compare.
  always @(posedge clk) begin : mon
    logic [1:0] xf;
    exp_t e;
    xf = rst_v & req_v & ack_v;
    #1;
    for (int ch = 0; ch < 2; ch++) begin
      if (xf[ch]) begin
        if (((ch == 0) ? sbq0.size() : sbq1.size()) == 0) begin
          checks++;
          errors++;
          $display("FAIL ch%0d unexpected_transfer flit_count=%0d required=no transfer", ch, fc_v[ch]);
        end else begin
          e = (ch == 0) ? sbq0.pop_front() : sbq1.pop_front();
          chk($sformatf("ch%0d flit_count", ch), fc_v[ch], e.cnt);
          chk($sformatf("ch%0d error_count", ch), ec_v[ch], e.err);
          chk($sformatf("ch%0d first_err_data", ch), fe_v[ch], e.first);
          chk($sformatf("ch%0d done", ch), done_v[ch], e.done);
          chk($sformatf("ch%0d timed_out", ch), to_v[ch], 0);
        end
      end
    end
  end

  // Golden backpressure model for channel 0: after the single idle cycle the
  // ack seen in each receive cycle is bit 0 of the seed stepped once per clock.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & 8'hB8)};
  endfunction

  logic [7:0] a_lfsr = 8'hA5;
  bit         a_started = 0;
  bit         a_term = 0;
  int         a_n = 0;

  always @(posedge clk) begin
    if (rst_v[0] !== 1'b1) begin
      a_lfsr = 8'hA5;
      a_started = 0;
      a_term = 0;
      a_n = 0;
    end else begin
      chk("ch0 ack_vs_lfsr", ack_v[0], (a_started && !a_term) ? a_lfsr[0] : 1'b0);
      if (a_started && !a_term && req_v[0] && ack_v[0]) begin
        a_n++;
        if (a_n == 4) a_term = 1;
      end
      a_started = 1;
      a_lfsr = lfsr_step(a_lfsr);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w;
    logic [7:0] d;
    bit seen;

    // Clean streams: stalled on ch0, back-to-back with wrap on ch1.
    reset_both();
    fork
      begin
        for (int k = 0; k < 4; k++) send(0, good_flit(0), $urandom_range(0, 2), w);
      end
      begin
        for (int k = 0; k < 5; k++) begin
          send(1, good_flit(1), 0, w);
          if (k > 0) chk($sformatf("ch1 back_to_back_wait flit%0d", k), w, 0);
        end
      end
    join
    final_chk(0, 1, 0);
    final_chk(1, 1, 0);

    // Error capture on ch0, idle timeout on ch1.
    reset_both();
    fork
      begin
        send(0, 8'h8A, 0, w);
        send(0, 8'h8B, 1, w);
        send(0, 8'h6C, 0, w);
        chk("ch0 first_err_after_bad_dest", fe_v[0], 8'h6C);
        send(0, 8'h8F, 2, w);
      end
      begin
        send(1, good_flit(1), 0, w);
        for (int i = 1; i <= 8; i++) begin
          @(negedge clk);
          chk($sformatf("ch1 timed_out_at_cycle_%0d", i), to_v[1], (i == 8));
        end
        req_v[1] = 1'b1;
        data_v[1] = good_flit(1);
        seen = 0;
        repeat (20) begin
          @(negedge clk);
          if (ack_v[1]) seen = 1;
        end
        chk("ch1 ack_after_timeout", seen, 0);
        req_v[1] = 1'b0;
      end
    join
    chk("ch0 error_count_two_bad", ec_v[0], 2);
    chk("ch0 first_err_kept", fe_v[0], 8'h6C);
    final_chk(0, 1, 0);
    final_chk(1, 0, 1);

    // Reset mid-transfer on ch0, random stream on ch1.
    reset_both();
    fork
      begin
        send(0, good_flit(0), 0, w);
        send(0, good_flit(0), 0, w);
        req_v[0] = 1'b1;
        data_v[0] = good_flit(0);
        rst_v[0] = 1'b0;
        #1;
        chk_zero(0, "mid_transfer_reset");
        clear_model(0);
        @(negedge clk);
        rst_v[0] = 1'b1;
        for (int k = 0; k < 4; k++) send(0, good_flit(0), 0, w);
      end
      begin
        for (int k = 0; k < 5; k++) begin
          rnd_flit(1, d);
          send(1, d, $urandom_range(0, 1), w);
        end
      end
    join
    final_chk(0, 1, 0);
    final_chk(1, 1, 0);

    // Randomized streams.
    repeat (4) begin
      reset_both();
      fork
        begin
          for (int k = 0; k < 4; k++) begin
            rnd_flit(0, d);
            send(0, d, $urandom_range(0, 3), w);
          end
        end
        begin
          for (int k = 0; k < 5; k++) begin
            rnd_flit(1, d);
            send(1, d, $urandom_range(0, 3), w);
          end
        end
      join
      final_chk(0, 1, 0);
      final_chk(1, 1, 0);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
